// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and byte width.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int BURST_CNT_W = 4;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: one-hot winner is the first asserted req
// at or after rr_ptr, wrapping past NUM_REQ-1 back to 0.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner
);

  // One extra bit on pos so rr_ptr + k cannot overflow before the wrap.
  always_comb begin
    logic [IDX_W:0] pos;
    logic           found;
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NUM_REQ)) begin
        pos = pos - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && req[pos[IDX_W-1:0]]) begin
        winner[pos[IDX_W-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters with bounded bursts.
// Define UART_ARB_PRIO0_EN to let requester 0 win every arbitration it enters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t               state;
  logic [IDX_W-1:0]         rr_ptr;
  logic [IDX_W-1:0]         gnt_idx;
  logic [IDX_W-1:0]         win_idx;
  logic [IDX_W-1:0]         next_ptr;
  logic [BURST_CNT_W-1:0]   burst_cnt;
  logic [BURST_CNT_W-1:0]   burst_nxt;
  logic                     last_q;
  logic [NUM_REQ-1:0]       rr_winner;
  logic [NUM_REQ-1:0]       winner;
  logic                     sel_req;
  logic                     sel_last;
  uart_byte_t               sel_data;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (rr_winner)
  );

`ifdef UART_ARB_PRIO0_EN
  assign winner = req[0] ? NUM_REQ'(1) : rr_winner;
`else
  assign winner = rr_winner;
`endif

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        win_idx = IDX_W'(i);
      end
    end
  end

  // Grant is one-hot, so masking and OR-ing acts as the data mux.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data = sel_data |
                 (req_data[UART_DATA_W*i +: UART_DATA_W] & {UART_DATA_W{grant[i]}});
    end
  end

  assign sel_req   = |(req & grant);
  assign sel_last  = |(req_last & grant);
  assign next_ptr  = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
  assign burst_nxt = burst_cnt + BURST_CNT_W'(1);

  // Strobes default low each cycle so tx_start and req_ack are single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      gnt_idx   <= '0;
      req_ack   <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      last_q    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      req_ack  <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant     <= winner;
            gnt_idx   <= win_idx;
            burst_cnt <= '0;
            state     <= ISSUE;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          if (!sel_req) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
            busy   <= 1'b0;
          end else if (!tx_busy) begin
            tx_start <= 1'b1;
            req_ack  <= grant;
            tx_data  <= sel_data;
            last_q   <= sel_last;
            state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            burst_cnt <= burst_nxt;
            if (last_q || (burst_nxt >= BURST_CNT_W'(MAX_BURST)) || !sel_req) begin
              rr_ptr <= next_ptr;
              grant  <= '0;
              state  <= IDLE;
              busy   <= 1'b0;
            end else begin
              state <= ISSUE;
            end
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with requester and UART models and a
// scoreboard of expected (grant, byte) pairs; honours UART_ARB_PRIO0_EN.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [7:0]    data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ack;
  logic [NR-1:0]   grant;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            tx_done;
  logic            busy;

  int         rem[NR];
  int         seq[NR];
  bit         drop[NR];
  logic [7:0] base[NR];
  int         uart_left;
  bit         busy_m;
  bit         force_busy;
  int         frame_len = 3;
  int         starts;
  int         overlaps;
  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .req_ack  (req_ack),
    .grant    (grant),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Requesters present base+seq; each ack consumes one byte of the message.
  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req[i]              = (rem[i] > 0) && !drop[i];
      req_last[i]         = (rem[i] == 1);
      req_data[8*i +: 8]  = base[i] + 8'(seq[i]);
    end
    tx_busy = busy_m | force_busy;
  endtask

  // One clock of the environment: UART frame timing plus requester bookkeeping.
  task automatic step();
    bit active;
    @(negedge clk);
    active = (uart_left > 0) || tx_done;
    if (tx_start) begin
      starts++;
      if (active) overlaps++;
    end
    if (tx_done) begin
      tx_done = 1'b0;
      busy_m  = 1'b0;
    end else if (uart_left > 0) begin
      uart_left--;
      if (uart_left == 0) tx_done = 1'b1;
    end
    if (tx_start) begin
      busy_m    = 1'b1;
      uart_left = frame_len;
    end
    for (int i = 0; i < NR; i++) begin
      if (req_ack[i]) begin
        seq[i]++;
        if (rem[i] > 0) rem[i]--;
      end
    end
    drive_reqs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rem[i]  = 0;
      seq[i]  = 0;
      drop[i] = 1'b0;
      base[i] = 8'(i * 16);
    end
    uart_left  = 0;
    busy_m     = 1'b0;
    tx_done    = 1'b0;
    force_busy = 1'b0;
    starts     = 0;
    overlaps   = 0;
    exp_q.delete();
    drive_reqs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) rem[i] = 5;
    drive_reqs();
    repeat (3) @(negedge clk);
    checks++;
    if (grant !== '0) begin errors++; $display("[TB] FAIL reset grant: got %b need 0000", grant); end
    checks++;
    if (req_ack !== '0) begin errors++; $display("[TB] FAIL reset req_ack: got %b need 0000", req_ack); end
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset tx_start: got %b need 0", tx_start); end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset tx_data: got %h need 00", tx_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b need 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    base[2] = 8'hA5;
    rem[2]  = 1;
    drive_reqs();
    step();
    checks++;
    if (grant !== 4'b0100 || tx_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single arb: got grant=%b start=%b busy=%b need 0100/0/1", grant, tx_start, busy);
    end
    step();
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5 || req_ack !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL single issue: got start=%b data=%h ack=%b need 1/a5/0100", tx_start, tx_data, req_ack);
    end
    for (int c = 0; c < 20 && busy !== 1'b0; c++) step();
    checks++;
    if (busy !== 1'b0 || grant !== '0 || starts != 1) begin
      errors++;
      $display("[TB] FAIL single release: got busy=%b grant=%b starts=%0d need 0/0000/1", busy, grant, starts);
    end
    rem[0] = 1; rem[1] = 1; rem[3] = 1;
    drive_reqs();
    step();
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL single rr_ptr: got grant=%b need 1000", grant);
    end
  endtask

  task automatic test_burst_rotation();
    int   nxt[NR];
    exp_t e;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      rem[i]  = 1000;
      base[i] = 8'(i * 64);
      nxt[i]  = 0;
    end
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        e.gnt  = NR'(1) << (b % NR);
        e.data = 8'(b % NR * 64 + nxt[b % NR]);
        nxt[b % NR]++;
        exp_q.push_back(e);
      end
    end
    drive_reqs();
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      step();
      if (tx_start) begin
        e = exp_q.pop_front();
        checks++;
        if ({grant, req_ack, tx_data} !== {e.gnt, e.gnt, e.data}) begin
          errors++;
          $display("[TB] FAIL burst byte: got grant=%b ack=%b data=%h need grant=%b ack=%b data=%h",
                   grant, req_ack, tx_data, e.gnt, e.gnt, e.data);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL burst timeout: got %0d bytes left need 0", exp_q.size()); end
    checks++;
    if (overlaps != 0) begin errors++; $display("[TB] FAIL burst overlap: got %0d starts in flight need 0", overlaps); end
  endtask

  task automatic test_tx_busy_hold();
    logic [7:0] seen;
    do_reset();
    force_busy = 1'b1;
    base[1]    = 8'h3C;
    rem[1]     = 1;
    seen       = 8'h00;
    drive_reqs();
    repeat (12) step();
    checks++;
    if (starts != 0 || grant !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL busy hold: got starts=%0d grant=%b need 0/0010", starts, grant);
    end
    force_busy = 1'b0;
    drive_reqs();
    for (int c = 0; c < 30 && busy !== 1'b0; c++) begin
      step();
      if (tx_start) seen = tx_data;
    end
    checks++;
    if (starts != 1 || seen !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL busy release: got starts=%0d data=%h need 1/3c", starts, seen);
    end
  endtask

  task automatic test_req_drop();
    exp_t e;
    do_reset();
    base[0] = 8'h10; rem[0] = 1000;
    base[2] = 8'h80; rem[2] = 1;
    exp_q.push_back('{gnt: 4'b0001, data: 8'h10});
    exp_q.push_back('{gnt: 4'b0100, data: 8'h80});
    drive_reqs();
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      step();
      if (tx_start) begin
        e = exp_q.pop_front();
        checks++;
        if ({grant, tx_data} !== {e.gnt, e.data}) begin
          errors++;
          $display("[TB] FAIL drop byte: got grant=%b data=%h need grant=%b data=%h", grant, tx_data, e.gnt, e.data);
        end
        drop[0] = 1'b1;
        drive_reqs();
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL drop timeout: got %0d bytes left need 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    exp_t e;
    do_reset();
    frame_len = 5;
    base[1] = 8'h55; rem[1] = 1;
    base[2] = 8'h66; rem[2] = 1000;
    exp_q.push_back('{gnt: 4'b0010, data: 8'h55});
    exp_q.push_back('{gnt: 4'b0100, data: 8'h66});
    drive_reqs();
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      step();
      if (tx_start) begin
        e = exp_q.pop_front();
        checks++;
        if ({grant, tx_data} !== {e.gnt, e.data}) begin
          errors++;
          $display("[TB] FAIL midrst pre byte: got grant=%b data=%h need grant=%b data=%h", grant, tx_data, e.gnt, e.data);
        end
      end
    end
    step();
    rst     = 1'b1;
    base[0] = 8'h11; rem[0] = 1000;
    rem[1]  = 1000;
    drive_reqs();
    step();
    checks++;
    if ({grant, req_ack, tx_start, tx_data, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL midrst outputs: got grant=%b ack=%b start=%b data=%h busy=%b need all 0",
               grant, req_ack, tx_start, tx_data, busy);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back('{gnt: 4'b0001, data: 8'h11});
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      step();
      if (tx_start) begin
        e = exp_q.pop_front();
        checks++;
        if ({grant, req_ack, tx_data} !== {e.gnt, e.gnt, e.data}) begin
          errors++;
          $display("[TB] FAIL midrst restart: got grant=%b ack=%b data=%h need grant=%b data=%h",
                   grant, req_ack, tx_data, e.gnt, e.data);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL midrst timeout: got %0d bytes left need 0", exp_q.size()); end
    frame_len = 3;
  endtask

  task automatic test_prio0();
    exp_t e;
    bit   armed;
    do_reset();
    base[0] = 8'h00;
    for (int i = 1; i < NR; i++) begin
      rem[i]  = 1000;
      base[i] = 8'(i * 32);
    end
    for (int k = 0; k < 4; k++) exp_q.push_back('{gnt: 4'b0010, data: 8'(32 + k)});
`ifdef UART_ARB_PRIO0_EN
    for (int k = 0; k < 4; k++) exp_q.push_back('{gnt: 4'b0001, data: 8'(k)});
`else
    for (int k = 0; k < 4; k++) exp_q.push_back('{gnt: 4'b0100, data: 8'(64 + k)});
`endif
    armed = 1'b0;
    drive_reqs();
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      step();
      if (tx_start) begin
        e = exp_q.pop_front();
        checks++;
        if ({grant, tx_data} !== {e.gnt, e.data}) begin
          errors++;
          $display("[TB] FAIL prio byte: got grant=%b data=%h need grant=%b data=%h", grant, tx_data, e.gnt, e.data);
        end
        if (!armed) begin
          armed  = 1'b1;
          rem[0] = 1000;
          drive_reqs();
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL prio timeout: got %0d bytes left need 0", exp_q.size()); end
  endtask

  initial begin
    rst        = 1'b1;
    tx_done    = 1'b0;
    busy_m     = 1'b0;
    force_busy = 1'b0;
    uart_left  = 0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0; seq[i] = 0; drop[i] = 1'b0; base[i] = 8'h00;
    end
    drive_reqs();
    $display("[TB] starting uart_tx_arbiter bench");
    test_reset();
    test_single();
    test_burst_rotation();
    test_tx_busy_hold();
    test_req_drop();
    test_reset_mid_frame();
    test_prio0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
